// File: rtl/z80_bus_trace.sv
// Z80 bus-activity monitor: filters the start of each memory/IO cycle into a
// valid/ready trace FIFO and keeps a small bank of software-written debug registers.
module z80_bus_trace #(
  parameter int          DEPTH    = 16,
  parameter int          AW       = 4,
  parameter int          NUM_DBG  = 2,
  parameter logic [7:0]  DBG_BASE = 8'h01,
  parameter int          OVF_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            z80_addr,
  input  logic [7:0]             z80_di,
  input  logic [7:0]             z80_do,
  input  logic                   z80_mem_rd,
  input  logic                   z80_mem_wr,
  input  logic                   z80_io_rd,
  input  logic                   z80_io_wr,
  input  logic                   capture_en,
  input  logic [3:0]             type_mask,
  input  logic [15:0]            win_lo,
  input  logic [15:0]            win_hi,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [25:0]            trace_data,
  output logic [AW:0]            fifo_level,
  output logic [OVF_W-1:0]       overflow_cnt,
  output logic [8*NUM_DBG-1:0]   dbg_regs
);

  // Bit index of each qualifier equals its record type code.
  logic [3:0]        w_qual;
  logic [3:0]        r_prev;
  logic [3:0]        w_rise;
  logic              w_evt;
  logic [1:0]        w_type;
  logic [7:0]        w_data;
  logic              w_in_win;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_en;
  logic              w_drop;
  logic [AW:0]       w_level;
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [OVF_W-1:0]  r_ovf;
  logic [25:0]       r_mem [DEPTH];
  logic [7:0]        r_dbg [NUM_DBG];

  assign w_qual = {z80_io_wr, z80_io_rd, z80_mem_wr, z80_mem_rd};
  assign w_rise = w_qual & ~r_prev;

  always_comb begin
    w_evt  = 1'b0;
    w_type = 2'd0;
    w_data = z80_di;
    if (w_rise[1]) begin
      w_evt  = 1'b1;
      w_type = 2'd1;
      w_data = z80_do;
    end else if (w_rise[0]) begin
      w_evt  = 1'b1;
      w_type = 2'd0;
      w_data = z80_di;
    end else if (w_rise[3]) begin
      w_evt  = 1'b1;
      w_type = 2'd3;
      w_data = z80_do;
    end else if (w_rise[2]) begin
      w_evt  = 1'b1;
      w_type = 2'd2;
      w_data = z80_di;
    end
  end

  // IO types (type[1]=1) bypass the memory window.
  assign w_in_win = (z80_addr >= win_lo) && (z80_addr <= win_hi);
  assign w_push   = w_evt && capture_en && type_mask[w_type] && (w_type[1] || w_in_win);

  assign w_level  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_level == (AW+1)'(DEPTH));
  assign w_empty  = (w_level == '0);
  assign w_pop    = !w_empty && trace_ready;
  assign w_wr_en  = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= '0;
    end else begin
      r_prev <= w_qual;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
    end
  end

  // When full with a simultaneous pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {w_type, z80_addr, w_data};
  end

  assign trace_data   = r_mem[r_rd_ptr[AW-1:0]];
  assign trace_valid  = !w_empty;
  assign fifo_level   = w_level;
  assign overflow_cnt = r_ovf;

  generate
    for (genvar gi = 0; gi < NUM_DBG; gi++) begin : g_dbg
      localparam logic [7:0] LP_PORT = DBG_BASE + 8'(gi);
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dbg[gi] <= 8'h00;
        end else if (w_rise[3] && (z80_addr[7:0] == LP_PORT)) begin
          r_dbg[gi] <= z80_do;
        end
      end
      assign dbg_regs[8*gi +: 8] = r_dbg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_z80_bus_trace.sv
// Bench for z80_bus_trace: vector table, directed multi-cycle sequences and
// randomized traffic against a queue-based reference model.
module tb_z80_bus_trace;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  qual;
  logic [15:0] addr;
  logic [7:0]  di;
  logic [7:0]  dout;
  logic        cen;
  logic [3:0]  mask;
  logic [15:0] lo;
  logic [15:0] hi;
  logic        ready;
  logic        trace_valid;
  logic [25:0] trace_data;
  logic [4:0]  fifo_level;
  logic [7:0]  overflow_cnt;
  logic [15:0] dbg_regs;

  int total = 0;
  int bad   = 0;

  logic [25:0] q[$];
  int          m_ovf;
  logic [3:0]  m_prev;
  logic [7:0]  m_dbg [2];

  z80_bus_trace dut (
    .clk(clk), .rst(rst), .z80_addr(addr), .z80_di(di), .z80_do(dout),
    .z80_mem_rd(qual[0]), .z80_mem_wr(qual[1]), .z80_io_rd(qual[2]), .z80_io_wr(qual[3]),
    .capture_en(cen), .type_mask(mask), .win_lo(lo), .win_hi(hi),
    .trace_valid(trace_valid), .trace_ready(ready), .trace_data(trace_data),
    .fifo_level(fifo_level), .overflow_cnt(overflow_cnt), .dbg_regs(dbg_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each edge applies pop, then the qualifying event (if any) per the rules.
  task automatic model_edge();
    logic [3:0]  rise;
    int          t;
    bit          pop, full, pass;
    logic [25:0] rec;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_prev = 0; m_dbg[0] = 0; m_dbg[1] = 0;
      return;
    end
    rise   = qual & ~m_prev;
    m_prev = qual;
    pop    = (q.size() > 0) && ready;
    full   = (q.size() == DEPTH);
    t = -1;
    if (rise[1]) t = 1; else if (rise[0]) t = 0; else if (rise[3]) t = 3; else if (rise[2]) t = 2;
    if (rise[3]) begin
      for (int k = 0; k < 2; k++)
        if (addr[7:0] == 8'(1 + k)) m_dbg[k] = dout;
    end
    if (pop) void'(q.pop_front());
    if (t >= 0) begin
      pass = cen && mask[t] && (t >= 2 || (addr >= lo && addr <= hi));
      rec  = {2'(t), addr, (t == 1 || t == 3) ? dout : di};
      if (pass) begin
        if (full && !pop) begin
          if (m_ovf < 255) m_ovf++;
        end else begin
          q.push_back(rec);
        end
      end
    end
  endtask

  task automatic chk_model();
    chk("m_valid", 32'(trace_valid), 32'(q.size() > 0));
    chk("m_level", 32'(fifo_level), 32'(q.size()));
    if (q.size() > 0) chk("m_data", 32'(trace_data), 32'(q[0]));
    chk("m_ovf", 32'(overflow_cnt), 32'(m_ovf));
    chk("m_dbg", 32'(dbg_regs), {16'h0, m_dbg[1], m_dbg[0]});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    rst = 1'b1; qual = 4'h0; ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  q;
    logic [15:0] addr;
    logic [7:0]  di;
    logic [7:0]  dout;
    logic        cen;
    logic [3:0]  mask;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        ev;
    logic [25:0] data;
  } vec_t;

  function automatic vec_t mk(logic [3:0] qq, logic [15:0] a, logic [7:0] r, logic [7:0] w,
                              logic c, logic [3:0] m, logic [15:0] l, logic [15:0] h,
                              logic e, logic [25:0] d);
    vec_t v;
    v.q = qq; v.addr = a; v.di = r; v.dout = w; v.cen = c; v.mask = m;
    v.lo = l; v.hi = h; v.ev = e; v.data = d;
    return v;
  endfunction

  vec_t vt [17];

  initial begin
    vt[0]  = mk(4'b0010, 16'hC010, 8'h00, 8'h5A, 1, 4'hF, 16'h0000, 16'hFFFF, 1, {2'd1, 16'hC010, 8'h5A});
    vt[1]  = mk(4'b0001, 16'h1234, 8'hA5, 8'h00, 1, 4'hF, 16'h0000, 16'hFFFF, 1, {2'd0, 16'h1234, 8'hA5});
    vt[2]  = mk(4'b0100, 16'h007E, 8'h42, 8'h00, 1, 4'hF, 16'h0000, 16'hFFFF, 1, {2'd2, 16'h007E, 8'h42});
    vt[3]  = mk(4'b1000, 16'h0080, 8'h00, 8'h99, 1, 4'hF, 16'h0000, 16'hFFFF, 1, {2'd3, 16'h0080, 8'h99});
    vt[4]  = mk(4'b0001, 16'h8000, 8'h11, 8'h00, 1, 4'hF, 16'hC000, 16'hDFFF, 0, 26'h0);
    vt[5]  = mk(4'b0001, 16'hC000, 8'h22, 8'h00, 1, 4'hF, 16'hC000, 16'hDFFF, 1, {2'd0, 16'hC000, 8'h22});
    vt[6]  = mk(4'b0001, 16'hDFFF, 8'h33, 8'h00, 1, 4'hF, 16'hC000, 16'hDFFF, 1, {2'd0, 16'hDFFF, 8'h33});
    vt[7]  = mk(4'b0001, 16'hE000, 8'h44, 8'h00, 1, 4'hF, 16'hC000, 16'hDFFF, 0, 26'h0);
    vt[8]  = mk(4'b0100, 16'h007E, 8'h55, 8'h00, 1, 4'hF, 16'hC000, 16'hDFFF, 1, {2'd2, 16'h007E, 8'h55});
    vt[9]  = mk(4'b0010, 16'h1800, 8'h00, 8'h66, 1, 4'hF, 16'h2000, 16'h1000, 0, 26'h0);
    vt[10] = mk(4'b0001, 16'h1234, 8'h77, 8'h00, 1, 4'hE, 16'h0000, 16'hFFFF, 0, 26'h0);
    vt[11] = mk(4'b1000, 16'h0080, 8'h00, 8'h88, 1, 4'h7, 16'h0000, 16'hFFFF, 0, 26'h0);
    vt[12] = mk(4'b0010, 16'h1234, 8'h00, 8'h99, 0, 4'hF, 16'h0000, 16'hFFFF, 0, 26'h0);
    vt[13] = mk(4'b1111, 16'h4000, 8'h88, 8'h77, 1, 4'hF, 16'h0000, 16'hFFFF, 1, {2'd1, 16'h4000, 8'h77});
    vt[14] = mk(4'b0101, 16'h4000, 8'h88, 8'h77, 1, 4'hF, 16'h0000, 16'hFFFF, 1, {2'd0, 16'h4000, 8'h88});
    vt[15] = mk(4'b1100, 16'h4080, 8'h88, 8'h77, 1, 4'hF, 16'h0000, 16'hFFFF, 1, {2'd3, 16'h4080, 8'h77});
    vt[16] = mk(4'b1000, 16'h0080, 8'h00, 8'hAB, 1, 4'hF, 16'hFFFF, 16'h0000, 1, {2'd3, 16'h0080, 8'hAB});

    addr = 16'h0; di = 8'h0; dout = 8'h0; cen = 1'b1; mask = 4'hF;
    lo = 16'h0000; hi = 16'hFFFF; qual = 4'h0; ready = 1'b0; rst = 1'b1;
    m_ovf = 0; m_prev = 0; m_dbg[0] = 0; m_dbg[1] = 0;

    do_reset();
    chk("rst_valid", 32'(trace_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(overflow_cnt), 0);
    chk("rst_dbg", 32'(dbg_regs), 0);

    foreach (vt[i]) begin
      addr = vt[i].addr; di = vt[i].di; dout = vt[i].dout; cen = vt[i].cen;
      mask = vt[i].mask; lo = vt[i].lo; hi = vt[i].hi; qual = vt[i].q; ready = 1'b0;
      step();
      chk($sformatf("tv%0d_valid", i), 32'(trace_valid), 32'(vt[i].ev));
      if (vt[i].ev) chk($sformatf("tv%0d_data", i), 32'(trace_data), 32'(vt[i].data));
      chk($sformatf("tv%0d_level", i), 32'(fifo_level), 32'(vt[i].ev));
      qual = 4'h0; ready = 1'b1;
      step();
      chk($sformatf("tv%0d_drain", i), 32'(fifo_level), 0);
    end
    chk("win_ovf", 32'(overflow_cnt), 0);

    // Held mem_rd produces exactly one record.
    cen = 1'b1; mask = 4'hF; lo = 16'h0000; hi = 16'hFFFF;
    addr = 16'h0100; di = 8'h3C; qual = 4'b0001; ready = 1'b0;
    repeat (4) step();
    chk("hold_level", 32'(fifo_level), 1);
    chk("hold_data", 32'(trace_data), {6'h0, 2'd0, 16'h0100, 8'h3C});
    qual = 4'h0; ready = 1'b1;
    step();
    chk("hold_drain", 32'(fifo_level), 0);

    // Overflow: 20 events into 16 slots, then in-order drain.
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      addr = 16'h2000 + 16'(i); dout = 8'(i * 3 + 1); qual = 4'b0010;
      step();
      qual = 4'h0;
      step();
    end
    chk("ovf_level", 32'(fifo_level), 16);
    chk("ovf_cnt", 32'(overflow_cnt), 4);
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("order%0d", i), 32'(trace_data), {6'h0, 2'd1, 16'h2000 + 16'(i), 8'(i * 3 + 1)});
      step();
    end
    chk("ovf_drained", 32'(fifo_level), 0);
    ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 16'h3000 + 16'(i); dout = 8'(i); qual = 4'b0010;
      step();
      qual = 4'h0;
      step();
    end
    chk("refill_level", 32'(fifo_level), 16);
    addr = 16'h3100; dout = 8'hEE; qual = 4'b0010; ready = 1'b1;
    step();
    chk("pp_level", 32'(fifo_level), 16);
    chk("pp_ovf", 32'(overflow_cnt), 4);
    qual = 4'h0;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("pp_order%0d", i), 32'(trace_data), {6'h0, 2'd1, 16'h3000 + 16'(i), 8'(i)});
      step();
    end
    chk("pp_tail", 32'(trace_data), {6'h0, 2'd1, 16'h3100, 8'hEE});
    step();
    chk("pp_drained", 32'(fifo_level), 0);

    // Saturation of the drop counter.
    ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      addr = 16'(i); qual = 4'b0010;
      step();
      qual = 4'h0;
      step();
    end
    chk("sat_ovf", 32'(overflow_cnt), 255);

    // Debug registers with capture disabled.
    do_reset();
    cen = 1'b0;
    addr = 16'h0001; dout = 8'h11; qual = 4'b1000; step(); qual = 4'h0; step();
    addr = 16'h0002; dout = 8'h22; qual = 4'b1000; step(); qual = 4'h0; step();
    addr = 16'h0003; dout = 8'h33; qual = 4'b1000; step(); qual = 4'h0; step();
    chk("dbg_regs", 32'(dbg_regs), 32'h2211);
    chk("dbg_level", 32'(fifo_level), 0);
    addr = 16'h0001; dout = 8'h44; qual = 4'b1000; step();
    dout = 8'h55; step(); step();
    qual = 4'h0; step();
    chk("dbg_hold", 32'(dbg_regs), 32'h2244);

    // Reset with 5 entries and 3 drops pending.
    cen = 1'b1; ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      addr = 16'h5000 + 16'(i); qual = 4'b0001; step(); qual = 4'h0; step();
    end
    ready = 1'b1;
    repeat (11) step();
    chk("pre_level", 32'(fifo_level), 5);
    chk("pre_ovf", 32'(overflow_cnt), 3);
    do_reset();
    chk("mid_valid", 32'(trace_valid), 0);
    chk("mid_level", 32'(fifo_level), 0);
    chk("mid_ovf", 32'(overflow_cnt), 0);
    chk("mid_dbg", 32'(dbg_regs), 0);

    // Randomized traffic against the model.
    begin
      int rp;
      rp = 50;
      for (int c = 0; c < 4000; c++) begin
        if (c % 500 == 0) rp = (c / 500) % 3 == 0 ? 10 : ((c / 500) % 3 == 1 ? 90 : 50);
        if (c % 200 == 0) begin
          mask = 4'($urandom_range(0, 15)) | 4'b0001;
          lo   = 16'($urandom_range(0, 16'h9000));
          hi   = 16'($urandom_range(0, 16'hFFFF));
          cen  = ($urandom_range(0, 9) != 0);
        end
        case ($urandom_range(0, 7))
          0, 1, 2: qual = 4'h0;
          3:       qual = 4'($urandom_range(0, 15));
          default: qual = 4'b0001 << $urandom_range(0, 3);
        endcase
        addr = 16'($urandom_range(0, 16'hFFFF));
        if ($urandom_range(0, 3) == 0) addr[7:0] = 8'($urandom_range(1, 3));
        di    = 8'($urandom_range(0, 255));
        dout  = 8'($urandom_range(0, 255));
        ready = ($urandom_range(0, 99) < rp);
        rst   = ($urandom_range(0, 999) == 0);
        step();
      end
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z80_bus_trace.md
Name: z80_bus_trace

Overview:
- Parametrised bus-activity monitor for the Z80 side of sggoc. Supersedes the ad-hoc single-register "debug port" capture and the simulation-only bus printouts.
- Detects the start of each memory or IO read/write cycle and filters it by event type and address window.
- Pushes one record per qualifying cycle into an internal FIFO, drained through a valid/ready port (UART bridge, logic analyser or testbench).
- Also latches a bank of NUM_DBG debug registers written by software through consecutive IO ports. Synthesisable; sits beside the mmu on z80_clk.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- AW, 4, log2(DEPTH).
- NUM_DBG, 2, number of debug IO registers, 1..8.
- DBG_BASE, 8'h01, IO address (low byte) of debug register 0; register k sits at DBG_BASE+k.
- OVF_W, 8, width of the overflow counter.

Ports:
- clk  in  1  Z80 clock (z80_clk).
- rst  in  1  synchronous active-high reset.
- z80_addr  in  16  Z80 address bus.
- z80_di  in  8  data into the Z80 (read data).
- z80_do  in  8  data out of the Z80 (write data).
- z80_mem_rd  in  1  memory read qualifier.
- z80_mem_wr  in  1  memory write qualifier.
- z80_io_rd  in  1  IO read qualifier.
- z80_io_wr  in  1  IO write qualifier.
- capture_en  in  1  when 0, no events are pushed; debug registers still update.
- type_mask  in  4  per-type enable, bit order {io_wr, io_rd, mem_wr, mem_rd}.
- win_lo  in  16  inclusive lower bound of the memory-address window.
- win_hi  in  16  inclusive upper bound of the memory-address window.
- trace_valid  out  1  FIFO head valid.
- trace_ready  in  1  consumer accepts the head.
- trace_data  out  26  {type[1:0], addr[15:0], data[7:0]}; type 0=mem_rd, 1=mem_wr, 2=io_rd, 3=io_wr.
- fifo_level  out  AW+1  current occupancy.
- overflow_cnt  out  OVF_W  dropped-event count, saturating.
- dbg_regs  out  8*NUM_DBG  debug register k at bits [8k+7:8k].

Behaviour:
- Reset (rst high at a clk edge):
  - trace_valid=0, fifo_level=0, overflow_cnt=0, dbg_regs=0.
  - All four previous-qualifier registers cleared to 0.
  - FIFO pointers reset.
  - trace_data is don't-care while trace_valid=0.
  - Reset mid-stream discards all entries with no partial output.
- Edge detect:
  - Each qualifier is registered every cycle.
  - A start event is qualifier=1 while its previous value=0.
  - A qualifier already high in the first cycle after reset counts as an event.
  - At most one qualifier is high per cycle. If several rise together, priority is mem_wr > mem_rd > io_wr > io_rd, and only that one is recorded.
- Record capture, all in the event cycle:
  - addr = z80_addr.
  - data = z80_di for reads, z80_do for writes.
- Filter. An event is pushed only if all of the following hold:
  - capture_en=1;
  - type_mask bit for its type = 1;
  - for mem types only, win_lo <= addr <= win_hi, unsigned.
  - IO events ignore the window.
  - win_lo > win_hi means no memory event passes.
- Latency:
  - An event in cycle N is written at the end of N.
  - It is visible on trace_data/trace_valid in cycle N+1 if the FIFO was empty.
  - No combinational path from bus inputs to trace outputs.
- Handshake:
  - Pop occurs when trace_valid && trace_ready at the clk edge.
  - trace_data holds stable while trace_valid=1 and no pop occurs.
  - trace_ready while empty has no effect.
- Full handling:
  - If the FIFO is full and no pop occurs in the same cycle, the push is dropped.
  - A dropped push increments overflow_cnt, saturating at 2^OVF_W-1. The FIFO is unchanged.
  - Push and pop in the same cycle when full: both happen, level stays DEPTH, no overflow.
  - Push and pop in the same cycle when non-empty: level unchanged, order preserved.
  - Push while empty: level goes 0->1, no same-cycle bypass.
- fifo_level counts 0..DEPTH; the extra pointer bit distinguishes full from empty.
- Debug registers:
  - On an io_wr start event with z80_addr[7:0] == DBG_BASE+k (k<NUM_DBG), dbg_regs[k] <= z80_do at that edge.
  - This is independent of capture_en, type_mask and FIFO state.
  - Writes to other ports leave all registers unchanged.
  - A held io_wr writes only once, on its start edge.

Test Plan:
- Reset, then mem_wr to 0xC010 with do=0x5A (window 0x0000..0xFFFF, mask=4'hF) -> trace_valid rises the next cycle with trace_data={2'd1,16'hC010,8'h5A}; level=1; pop with ready=1 returns level to 0.
- Hold mem_rd high 4 cycles at 0x0100 with di=0x3C -> exactly one record {0,0x0100,0x3C}.
- Window 0xC000..0xDFFF: mem_rd at 0x8000 and 0xC000, then io_rd at 0x7E -> two records (0xC000 mem, 0x7E io); 0x8000 dropped, overflow_cnt stays 0.
- ready=0 with 20 distinct mem_wr events (DEPTH=16) -> level=16, overflow_cnt=4; draining returns the first 16 events in order. Then a full-FIFO push plus pop in the same cycle -> level stays 16, overflow_cnt stays 4.
- io_wr to 0x01 with do=0x11, then to 0x02 with do=0x22, then to 0x03 with do=0x33, with capture_en=0 -> dbg_regs=16'h2211, FIFO empty.
- Assert rst with the FIFO holding 5 entries and overflow_cnt=3 -> next cycle trace_valid=0, level=0, overflow_cnt=0, dbg_regs=0.
